bitbakery_frame_tx: RTL

BITBAKERY_FRAME_TX -- requirements
Module: bitbakery_frame_tx

---
 rtl/bitbakery_frame_tx.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/bitbakery_frame_tx.sv
// Packet serializer: sends NUM_BYTES bytes as back-to-back asynchronous serial
// frames (start bit, DATA_BITS data bits LSB first, optional parity, stop bits).
// Ports:
//   clock        - single clock, rising edge
//   reset        - asynchronous active-high reset
//   start        - packet request, sampled only while idle
//   continuous   - restart immediately with a fresh payload after each packet
//   data_in      - payload; byte k = data_in[k*DATA_BITS +: DATA_BITS]
//   saida_serial - serial line, idle high
//   busy         - high while a packet is in progress
//   done         - one-cycle pulse on the last cycle of each packet
//   byte_index   - index of the byte currently on the line
module bitbakery_frame_tx #(
  parameter int unsigned CLK_DIV     = 434,
  parameter int unsigned NUM_BYTES   = 4,
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned PARITY_MODE = 1,
  parameter int unsigned STOP_BITS   = 1,
  localparam int unsigned BIW = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           start,
  input  logic                           continuous,
  input  logic [NUM_BYTES*DATA_BITS-1:0] data_in,
  output logic                           saida_serial,
  output logic                           busy,
  output logic                           done,
  output logic [BIW-1:0]                 byte_index
);

  localparam int unsigned PW = NUM_BYTES * DATA_BITS;
  localparam int unsigned TW = 16;
  localparam int unsigned BW = 3;

  localparam logic [TW-1:0]  TICK_LAST = TW'(CLK_DIV - 1);
  localparam logic [BW-1:0]  DATA_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0]  STOP_LAST = BW'(STOP_BITS - 1);
  localparam logic [BIW-1:0] BYTE_LAST = BIW'(NUM_BYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  state_e           state_q, state_d;
  logic [TW-1:0]    tick_q, tick_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic [BIW-1:0]   byte_q, byte_d;
  logic [PW-1:0]    pkt_q, pkt_d;
  logic             bit_end;
  logic             serial_d, busy_d, done_d;
  logic [DATA_BITS-1:0] cur_byte, cur_shift;

  // State, counters and registered outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      tick_q       <= '0;
      bit_q        <= '0;
      byte_q       <= '0;
      pkt_q        <= '0;
      saida_serial <= 1'b1;
      busy         <= 1'b0;
      done         <= 1'b0;
      byte_index   <= '0;
    end else begin
      state_q      <= state_d;
      tick_q       <= tick_d;
      bit_q        <= bit_d;
      byte_q       <= byte_d;
      pkt_q        <= pkt_d;
      saida_serial <= serial_d;
      busy         <= busy_d;
      done         <= done_d;
      byte_index   <= byte_d;
    end
  end

  // Next state: every bit lasts CLK_DIV ticks; bit_q indexes data or stop bits
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    pkt_d   = pkt_q;
    bit_end = (tick_q == TICK_LAST);
    if (state_q == S_IDLE) begin
      if (start) begin
        state_d = S_START;
        pkt_d   = data_in;
        tick_d  = '0;
        bit_d   = '0;
        byte_d  = '0;
      end
    end else if (!bit_end) begin
      tick_d = tick_q + TW'(1);
    end else begin
      tick_d = '0;
      bit_d  = '0;
      case (state_q)
        S_START: state_d = S_DATA;
        S_DATA: begin
          if (bit_q != DATA_LAST) begin
            bit_d = bit_q + BW'(1);
          end else begin
            state_d = (PARITY_MODE != 0) ? S_PARITY : S_STOP;
          end
        end
        S_PARITY: state_d = S_STOP;
        S_STOP: begin
          if (bit_q != STOP_LAST) begin
            bit_d = bit_q + BW'(1);
          end else if (byte_q != BYTE_LAST) begin
            state_d = S_START;
            byte_d  = byte_q + BIW'(1);
          end else if (continuous) begin
            // Next packet starts with no idle gap and a fresh payload
            state_d = S_START;
            byte_d  = '0;
            pkt_d   = data_in;
          end else begin
            state_d = S_IDLE;
            byte_d  = '0;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Outputs decoded from the next state so they land in registers aligned with it
  always_comb begin
    cur_byte  = DATA_BITS'(pkt_d >> (32'(byte_d) * DATA_BITS));
    cur_shift = cur_byte >> bit_d;
    serial_d  = 1'b1;
    busy_d    = (state_d != S_IDLE);
    done_d    = (state_d == S_STOP) && (tick_d == TICK_LAST) &&
                (bit_d == STOP_LAST) && (byte_d == BYTE_LAST);
    case (state_d)
      S_START:  serial_d = 1'b0;
      S_DATA:   serial_d = cur_shift[0];
      S_PARITY: serial_d = (PARITY_MODE == 2) ? ~(^cur_byte) : ^cur_byte;
      default:  serial_d = 1'b1;
    endcase
  end

endmodule
